// File: rtl/aes_pkg.sv
// Shared types for the AES job scheduler: block width, block type and scheduler states.
package aes_pkg;

    localparam int AES_BLOCK_W = 128;

    typedef logic [AES_BLOCK_W-1:0] aes_block_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2,
        GAP  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester after last_grant, wrapping.
// The pointer register is owned by the caller.
module rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] index,
    output logic             any
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant = '0;
        index = '0;
        any   = 1'b0;
        cand  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IDX_W'((int'(last_grant) + k) % N_REQ);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                index       = cand;
            end
        end
    end

endmodule

// File: rtl/aes_job_scheduler.sv
// Round-robin front end for a single AES-128 core: grants one job at a time, times the
// core latency, returns the ciphertext tagged with the requester index.
module aes_job_scheduler
    import aes_pkg::*;
#(
    parameter  int N_REQ        = 4,
    parameter  int CORE_LATENCY = 32,
    parameter  int GAP_CYCLES   = 2,
    localparam int IDX_W        = $clog2(N_REQ)
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic [N_REQ-1:0]             req_valid,
    output logic [N_REQ-1:0]             req_ready,
    input  logic [N_REQ*AES_BLOCK_W-1:0] req_key,
    input  logic [N_REQ*AES_BLOCK_W-1:0] req_data,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [IDX_W-1:0]             resp_id,
    output logic [AES_BLOCK_W-1:0]       resp_data,
    output logic                         core_enable,
    output logic [AES_BLOCK_W-1:0]       core_key,
    output logic [AES_BLOCK_W-1:0]       core_data,
    input  logic [AES_BLOCK_W-1:0]       core_result,
    output logic                         busy
);

    localparam int CNT_W    = $clog2(CORE_LATENCY) + 1;
    localparam int GAP_LAST = (GAP_CYCLES > 2) ? GAP_CYCLES - 2 : 0;

    sched_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] last_grant_q, last_grant_d;
    logic             core_enable_q, core_enable_d;
    aes_block_t       core_key_q, core_key_d;
    aes_block_t       core_data_q, core_data_d;
    logic             resp_valid_q, resp_valid_d;
    logic [IDX_W-1:0] resp_id_q, resp_id_d;
    aes_block_t       resp_data_q, resp_data_d;
    logic             busy_q, busy_d;

    logic [N_REQ-1:0] arb_grant;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_any;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .grant      (arb_grant),
        .index      (arb_idx),
        .any        (arb_any)
    );

    // Grant is only offered while idle and out of reset, so it can never leak during reset.
    assign req_ready = (state_q == IDLE && n_rst) ? arb_grant : '0;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        last_grant_d  = last_grant_q;
        core_enable_d = core_enable_q;
        core_key_d    = core_key_q;
        core_data_d   = core_data_q;
        resp_valid_d  = resp_valid_q;
        resp_id_d     = resp_id_q;
        resp_data_d   = resp_data_q;
        busy_d        = busy_q;

        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    core_key_d    = req_key[AES_BLOCK_W*int'(arb_idx) +: AES_BLOCK_W];
                    core_data_d   = req_data[AES_BLOCK_W*int'(arb_idx) +: AES_BLOCK_W];
                    resp_id_d     = arb_idx;
                    last_grant_d  = arb_idx;
                    cnt_d         = '0;
                    core_enable_d = 1'b1;
                    busy_d        = 1'b1;
                    state_d       = RUN;
                end
            end
            RUN: begin
                if (cnt_q == CNT_W'(CORE_LATENCY - 1)) begin
                    resp_data_d  = core_result;
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d  = 1'b0;
                    core_enable_d = 1'b0;
                    cnt_d         = '0;
                    state_d       = GAP;
                end
            end
            GAP: begin
                // The IDLE grant cycle is the final low cycle of the enable gap, so GAP itself
                // lasts one cycle less than the full gap.
                if (cnt_q >= CNT_W'(GAP_LAST)) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            last_grant_q  <= IDX_W'(N_REQ - 1);
            core_enable_q <= 1'b0;
            core_key_q    <= '0;
            core_data_q   <= '0;
            resp_valid_q  <= 1'b0;
            resp_id_q     <= '0;
            resp_data_q   <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            last_grant_q  <= last_grant_d;
            core_enable_q <= core_enable_d;
            core_key_q    <= core_key_d;
            core_data_q   <= core_data_d;
            resp_valid_q  <= resp_valid_d;
            resp_id_q     <= resp_id_d;
            resp_data_q   <= resp_data_d;
            busy_q        <= busy_d;
        end
    end

    assign core_enable = core_enable_q;
    assign core_key    = core_key_q;
    assign core_data   = core_data_q;
    assign resp_valid  = resp_valid_q;
    assign resp_id     = resp_id_q;
    assign resp_data   = resp_data_q;
    assign busy        = busy_q;

endmodule
